// File: rtl/audio_decimator.sv
// Box-filter decimator: averages every stereo sample received in each output
// period and presents one held stereo word per period with a valid pulse.
module audio_decimator #(
  parameter int unsigned CLK_HZ = 32000000,
  parameter int unsigned RATE   = 48000,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned ACC_W  = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_strobe,
  input  logic [15:0] in_l,
  input  logic [15:0] in_r,
  output logic [15:0] out_l,
  output logic [15:0] out_r,
  output logic        out_valid,
  output logic        busy,
  output logic        overrun
);

  localparam int unsigned PERIOD = CLK_HZ / RATE;
  localparam int unsigned TICK_W = $clog2(PERIOD);
  localparam int unsigned DCNT_W = $clog2(ACC_W);
  localparam int unsigned SEXT_W = ACC_W - 16;

  if (PERIOD < 64) begin : g_period_chk
    $error("audio_decimator: CLK_HZ/RATE must be at least 64");
  end
  if (ACC_W < 16 + CNT_W) begin : g_acc_chk
    $error("audio_decimator: ACC_W must be at least 16+CNT_W");
  end

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  logic [1:0]        state, state_d;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick_c;
  logic [ACC_W-1:0]  acc_l, acc_r;
  logic [CNT_W-1:0]  n;
  logic [ACC_W-1:0]  sext_l_c, sext_r_c, abs_l_c, abs_r_c;
  logic [ACC_W-1:0]  quo_l, quo_r;
  logic [CNT_W-1:0]  rem_l, rem_r, dvs;
  logic              neg_l, neg_r;
  logic [DCNT_W-1:0] div_cnt;
  logic [CNT_W+ACC_W-1:0] step_l_c, step_r_c;
  logic [ACC_W-1:0]  quo_fin_l_c, quo_fin_r_c;
  logic              ld_out_c;

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  function automatic logic [CNT_W+ACC_W-1:0] div_step(
    input logic [CNT_W-1:0] rem,
    input logic [ACC_W-1:0] quo,
    input logic [CNT_W-1:0] divisor
  );
    logic [CNT_W:0] trial;
    trial = {rem, quo[ACC_W-1]};
    if (trial >= {1'b0, divisor}) begin
      div_step = {CNT_W'(trial - {1'b0, divisor}), quo[ACC_W-2:0], 1'b1};
    end else begin
      div_step = {trial[CNT_W-1:0], quo[ACC_W-2:0], 1'b0};
    end
  endfunction

  assign tick_c      = (tick_cnt == TICK_W'(PERIOD - 1));
  assign sext_l_c    = {{SEXT_W{in_l[15]}}, in_l};
  assign sext_r_c    = {{SEXT_W{in_r[15]}}, in_r};
  assign abs_l_c     = acc_l[ACC_W-1] ? (ACC_W'(0) - acc_l) : acc_l;
  assign abs_r_c     = acc_r[ACC_W-1] ? (ACC_W'(0) - acc_r) : acc_r;
  assign step_l_c    = div_step(rem_l, quo_l, dvs);
  assign step_r_c    = div_step(rem_r, quo_r, dvs);
  assign quo_fin_l_c = step_l_c[ACC_W-1:0];
  assign quo_fin_r_c = step_r_c[ACC_W-1:0];

  // Output-rate tick counter
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick_c) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // Window accumulation; a sample coincident with the tick opens the next window
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_l   <= '0;
      acc_r   <= '0;
      n       <= '0;
      overrun <= 1'b0;
    end else if (tick_c) begin
      acc_l <= in_strobe ? sext_l_c : '0;
      acc_r <= in_strobe ? sext_r_c : '0;
      n     <= in_strobe ? CNT_W'(1) : '0;
    end else if (in_strobe) begin
      if (n == '1) begin
        overrun <= 1'b1;
      end else begin
        acc_l <= acc_l + sext_l_c;
        acc_r <= acc_r + sext_r_c;
        n     <= n + CNT_W'(1);
      end
    end
  end

  // Divider datapath: magnitudes are snapped at the tick, signs reapplied at the end
  always_ff @(posedge clk) begin
    if (reset) begin
      quo_l   <= '0;
      quo_r   <= '0;
      rem_l   <= '0;
      rem_r   <= '0;
      dvs     <= '0;
      neg_l   <= 1'b0;
      neg_r   <= 1'b0;
      div_cnt <= '0;
    end else if (tick_c) begin
      quo_l   <= abs_l_c;
      quo_r   <= abs_r_c;
      rem_l   <= '0;
      rem_r   <= '0;
      dvs     <= n;
      neg_l   <= acc_l[ACC_W-1];
      neg_r   <= acc_r[ACC_W-1];
      div_cnt <= '0;
    end else if (state == S_DIV) begin
      {rem_l, quo_l} <= step_l_c;
      {rem_r, quo_r} <= step_r_c;
      div_cnt        <= div_cnt + DCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d  = state;
    ld_out_c = 1'b0;
    case (state)
      S_IDLE: if (tick_c) state_d = (n == '0) ? S_HOLD : S_DIV;
      S_DIV: begin
        if (div_cnt == DCNT_W'(ACC_W - 1)) begin
          state_d  = S_OUT;
          ld_out_c = 1'b1;
        end
      end
      S_HOLD:  state_d = S_OUT;
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs, timed off the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_l     <= '0;
      out_r     <= '0;
    end else begin
      out_valid <= (state_d == S_OUT);
      busy      <= (state_d == S_DIV);
      if (ld_out_c) begin
        out_l <= neg_l ? 16'(ACC_W'(0) - quo_fin_l_c) : 16'(quo_fin_l_c);
        out_r <= neg_r ? 16'(ACC_W'(0) - quo_fin_r_c) : 16'(quo_fin_r_c);
      end
    end
  end

endmodule

// File: tb/tb_audio_decimator.sv
// Directed bench for audio_decimator at default parameters (PERIOD = 666).
// Cycle 1 is the first cycle with reset low; the first tick is cycle 666.
module tb_audio_decimator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_strobe = 1'b0;
  logic [15:0] in_l = '0;
  logic [15:0] in_r = '0;
  logic [15:0] out_l, out_r;
  logic        out_valid, busy, overrun;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  audio_decimator dut (
    .clk       (clk),
    .reset     (reset),
    .in_strobe (in_strobe),
    .in_l      (in_l),
    .in_r      (in_r),
    .out_l     (out_l),
    .out_r     (out_r),
    .out_valid (out_valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_to(input int c);
    while (cyc < c) step();
  endtask

  // Sample presented in the current cycle
  task automatic strobe(input int l, input int r);
    in_strobe = 1'b1;
    in_l = 16'(l);
    in_r = 16'(r);
    step();
    in_strobe = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_strobe = 1'b0;
    step();
    step();
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_l", $signed(out_l), 0);
    chk("rst_r", $signed(out_r), 0);
    reset = 1'b0;
    cyc = 1;
  endtask

  // Advance to the next out_valid pulse and check when it came and what it carried
  task automatic wait_valid(input string tag, input int exp_cyc, input int exp_l, input int exp_r);
    int guard = 0;
    while (!out_valid && guard < 3000) begin
      step();
      guard++;
    end
    chk({tag, "_cyc"}, cyc, exp_cyc);
    chk({tag, "_l"}, $signed(out_l), exp_l);
    chk({tag, "_r"}, $signed(out_r), exp_r);
    chk({tag, "_busy"}, int'(busy), 0);
    step();
    chk({tag, "_pulse"}, int'(out_valid), 0);
  endtask

  initial begin
    // Idle: empty windows give out_valid at tick+2 with zero output, never busy
    do_reset();
    while (cyc <= 2000) begin
      int exp_v;
      exp_v = (cyc == 668 || cyc == 1334 || cyc == 2000) ? 1 : 0;
      chk("idle_valid", int'(out_valid), exp_v);
      chk("idle_busy", int'(busy), 0);
      if (exp_v == 1) begin
        chk("idle_l", $signed(out_l), 0);
        chk("idle_r", $signed(out_r), 0);
      end
      step();
    end

    // Four-sample average, plus one sample arriving mid-division for the next window
    do_reset();
    idle_to(10);  strobe(100, -100);
    idle_to(20);  strobe(200, -100);
    idle_to(30);  strobe(300, -100);
    idle_to(40);  strobe(401, -100);
    idle_to(666);
    chk("div_busy_pre", int'(busy), 0);
    step();
    chk("div_busy_start", int'(busy), 1);
    idle_to(680);
    strobe(7, -7);
    chk("div_busy_mid", int'(busy), 1);
    wait_valid("avg4", 691, 250, -100);
    wait_valid("n1", 1357, 7, -7);

    // Negative truncation toward zero, then an empty window holds the value
    do_reset();
    idle_to(50);
    strobe(-1, 3);
    strobe(-2, 4);
    wait_valid("neg", 691, -1, 3);
    wait_valid("hold", 1334, -1, 3);

    // Sample coincident with the tick belongs to the next window
    do_reset();
    idle_to(100);
    strobe(10, 10);
    idle_to(666);
    strobe(1000, -1000);
    wait_valid("coinc1", 691, 10, 10);
    wait_valid("coinc2", 1357, 1000, -1000);

    // Counter saturation: the 256th sample is dropped and overrun sticks
    do_reset();
    idle_to(2);
    for (int i = 1; i <= 300; i++) begin
      strobe(32767, 32767);
      if (i == 255) chk("ovr_before", int'(overrun), 0);
      if (i == 256) chk("ovr_set", int'(overrun), 1);
    end
    wait_valid("sat", 691, 32767, 32767);
    idle_to(700);
    strobe(1, 1);
    strobe(1, 1);
    wait_valid("after_sat", 1357, 1, 1);
    chk("ovr_sticky", int'(overrun), 1);

    // Most-negative extreme, then reset in the middle of a division
    do_reset();
    idle_to(5);
    strobe(-32768, 5);
    strobe(-32768, 5);
    strobe(-32768, 5);
    wait_valid("min", 691, -32768, 5);
    idle_to(700);
    strobe(3, 3);
    idle_to(1342);
    chk("abort_busy", int'(busy), 1);
    reset = 1'b1;
    step();
    chk("abort_valid", int'(out_valid), 0);
    chk("abort_busy_clr", int'(busy), 0);
    chk("abort_l", $signed(out_l), 0);
    chk("abort_r", $signed(out_r), 0);
    reset = 1'b0;
    cyc = 1;
    wait_valid("post_rst", 668, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
